// File: rtl/cpu_issuer_pkg.sv
// Shared types and constants for the operation issuer.
// Port widths, controller output indices, FSM states, completion codes.
package cpu_issuer_pkg;

  localparam int X_W     = 14;
  localparam int Y_W     = 29;
  localparam int Y19_IDX = 18;
  localparam int Y20_IDX = 19;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DK_Y19 = 2'b00,
    DK_Y20 = 2'b01,
    DK_TMO = 2'b10,
    DK_RSV = 2'b11
  } done_kind_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous increment.
// Asynchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_op_issuer.sv
// Issues condition vectors to a microprogram controller and
// watches its outputs for completion, timeout and silent steps.
module cpu_op_issuer
  import cpu_issuer_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [X_W-1:0]   op_word,
  input  logic [Y_W-1:0]   y_in,
  output logic [X_W-1:0]   x_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_kind,
  output logic             silent_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] silent_count
);

  localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] LAST = SW'(TIMEOUT - 1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("cpu_op_issuer: TIMEOUT must be at least 2");
  end

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] step_cnt;
  logic          y19;
  logic          y20;
  logic          last;
  logic          silent;
  logic          run;
  logic          accept;

  assign y19    = y_in[Y19_IDX];
  assign y20    = y_in[Y20_IDX];
  assign last   = (step_cnt == LAST);
  assign silent = (y_in == '0);
  assign run    = (state == S_RUN);
  assign accept = (state == S_IDLE) && op_valid;

  assign op_ready = (state == S_IDLE);
  assign busy     = (state == S_RUN) || (state == S_DONE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (op_valid) state_nxt = S_RUN;
      S_RUN:  if (y19 || y20 || last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out      <= '0;
      step_cnt   <= '0;
      done_kind  <= DK_Y19;
      silent_err <= 1'b0;
    end else begin
      if (accept) begin
        x_out    <= op_word;
        step_cnt <= '0;
      end
      if (run) begin
        step_cnt <= step_cnt + 1'b1;
        if (silent) silent_err <= 1'b1;
        // y19 beats y20 beats timeout
        if (y19)       done_kind <= DK_Y19;
        else if (y20)  done_kind <= DK_Y20;
        else if (last) done_kind <= DK_TMO;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_op_cnt (
    .clk (clk),
    .rst (rst),
    .inc (done),
    .cnt (op_count)
  );

  sat_counter #(.W(CNT_W)) u_silent_cnt (
    .clk (clk),
    .rst (rst),
    .inc (run && silent),
    .cnt (silent_count)
  );

endmodule

// File: tb/tb_cpu_op_issuer.sv
// Directed bench for cpu_op_issuer; controller outputs are
// driven as hand-written y sequences on the falling edge.
module tb_cpu_op_issuer;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [13:0] op_word;
  logic [28:0] y_in;
  logic [13:0] x_out;
  logic        busy;
  logic        done;
  logic [1:0]  done_kind;
  logic        silent_err;
  logic [3:0]  op_count;
  logic [3:0]  silent_count;

  int nvec = 0;
  int nerr = 0;

  localparam logic [28:0] Y1   = 29'h1;
  localparam logic [28:0] Y19  = 29'h1 << 18;
  localparam logic [28:0] Y20  = 29'h1 << 19;
  localparam logic [28:0] YNIL = 29'h0;

  cpu_op_issuer #(.TIMEOUT(32), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_word      (op_word),
    .y_in         (y_in),
    .x_out        (x_out),
    .busy         (busy),
    .done         (done),
    .done_kind    (done_kind),
    .silent_err   (silent_err),
    .op_count     (op_count),
    .silent_count (silent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with the FSM in IDLE.
  task automatic op(input string tg, input logic [13:0] w, input int n,
                    input logic [28:0] fill, input logic [28:0] yf,
                    input int zi, input logic [1:0] kind);
    op_valid = 1'b1;
    op_word  = w;
    y_in     = fill;
    @(negedge clk);
    op_valid = 1'b0;
    check({tg, "_acc_x"}, 32'(x_out), 32'(w));
    check({tg, "_acc_busy"}, 32'(busy), 1);
    check({tg, "_acc_rdy"}, 32'(op_ready), 0);
    for (int i = 1; i <= n; i++) begin
      y_in = (i == n) ? yf : ((i == zi) ? YNIL : fill);
      @(negedge clk);
      if (i < n) check({tg, "_early_done"}, 32'(done), 0);
    end
    y_in = YNIL;
    check({tg, "_done"}, 32'(done), 1);
    check({tg, "_kind"}, 32'(done_kind), 32'(kind));
    @(negedge clk);
    check({tg, "_done_off"}, 32'(done), 0);
    check({tg, "_rdy"}, 32'(op_ready), 1);
    check({tg, "_x_hold"}, 32'(x_out), 32'(w));
    check({tg, "_kind_hold"}, 32'(done_kind), 32'(kind));
  endtask

  // op_valid held high with y19 present: IDLE, RUN, DONE repeat.
  task automatic held(input string tg, input int nops);
    int pulses;
    pulses   = 0;
    op_valid = 1'b1;
    op_word  = 14'h0006;
    y_in     = Y19;
    for (int k = 1; k <= 3 * nops; k++) begin
      @(negedge clk);
      if (done) pulses++;
      check({tg, "_rdy"}, 32'(op_ready), (k % 3 == 0) ? 1 : 0);
      check({tg, "_done"}, 32'(done), (k % 3 == 2) ? 1 : 0);
    end
    op_valid = 1'b0;
    y_in     = YNIL;
    check({tg, "_pulses"}, 32'(pulses), 32'(nops));
  endtask

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    op_word  = '0;
    y_in     = YNIL;
    @(negedge clk);
    check("rst_rdy", 32'(op_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_x", 32'(x_out), 0);
    check("rst_kind", 32'(done_kind), 0);
    check("rst_serr", 32'(silent_err), 0);
    check("rst_ops", 32'(op_count), 0);
    check("rst_sil", 32'(silent_count), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 32'(op_ready), 1);

    // x2,x4,x11: six samples, y19 on the last
    op("s1", 14'h040A, 6, Y1, Y19, 0, 2'b00);
    check("s1_ops", 32'(op_count), 1);

    // x2,x4,x12: seven samples, y20 on the last
    op("s2", 14'h080A, 7, Y1, Y20, 0, 2'b01);
    op("prio", 14'h080A, 2, Y1, Y19 | Y20, 0, 2'b00);
    check("s2_ops", 32'(op_count), 3);
    check("s2_sil", 32'(silent_count), 0);

    // x2,x3 five times; the fifth has one all-zero step
    for (int k = 0; k < 5; k++)
      op("s3", 14'h0006, 4, Y1, Y19, (k == 4) ? 2 : 0, 2'b00);
    check("s3_ops", 32'(op_count), 8);
    check("s3_sil", 32'(silent_count), 1);
    check("s3_serr", 32'(silent_err), 1);

    // no completion: timeout on the 32nd sample
    op("s4", 14'h0000, 32, Y1, Y1, 0, 2'b10);
    op("s4z", 14'h0000, 32, Y1, YNIL, 0, 2'b10);
    check("s4_ops", 32'(op_count), 10);
    check("s4_sil", 32'(silent_count), 2);

    held("s5", 3);
    check("s5_ops", 32'(op_count), 13);
    check("s5_x", 32'(x_out), 32'(14'h0006));

    // reset at RUN step 3
    op_valid = 1'b1;
    op_word  = 14'h040A;
    @(negedge clk);
    op_valid = 1'b0;
    y_in     = Y1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("s6_done", 32'(done), 0);
    check("s6_x", 32'(x_out), 0);
    check("s6_ops", 32'(op_count), 0);
    check("s6_sil", 32'(silent_count), 0);
    check("s6_serr", 32'(silent_err), 0);
    check("s6_rdy", 32'(op_ready), 1);
    @(negedge clk);
    rst  = 1'b0;
    y_in = YNIL;
    @(negedge clk);
    check("s6_rdy_next", 32'(op_ready), 1);
    check("s6_no_done", 32'(done), 0);
    check("s6_kind", 32'(done_kind), 0);

    // 4-bit counters must stick at 15
    held("sat", 16);
    check("sat_ops", 32'(op_count), 15);
    op("satz", 14'h0001, 32, YNIL, YNIL, 0, 2'b10);
    check("sat_sil", 32'(silent_count), 15);
    check("sat_ops2", 32'(op_count), 15);
    check("sat_serr", 32'(silent_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
